conv1d_v4: RTL
==============

CONV1D_V4 -- requirements
Module: conv1d_v4

Interface
REQ-001 SHALL have parameter KERNEL_LEN, default 8, kernel taps.
REQ-002 SHALL have parameter MAX_INPUT_LEN, default 1024, input buffer rows.
REQ-003 SHALL have parameter MAX_CHANNELS, default 128, input channels per row; SHALL be a multiple of 4.
REQ-004 SHALL have parameter ACC_W, default 32, accumulator and output width.
REQ-005 SHALL have one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-007 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-008 SHALL have port cmd, input, 7 bits, command code; 0 = NOP.
REQ-009 SHALL have port inp0, input, 32 bits, signed, address or operand A.
REQ-010 SHALL have port inp1, input, 32 bits, signed, data or operand B.
REQ-011 SHALL have port output_buffer_valid, output, 1 bit, outputs complete and readable.
REQ-012 SHALL have port busy, output, 1 bit, computation in progress.
REQ-013 SHALL have port ret, output, ACC_W bits, signed, registered read data.

Function
REQ-014 SHALL execute the cmd present on every rising clk edge; cmd is level-sampled and carries no handshake.
REQ-015 SHALL decode cmd 1 as: write inp1 bytes [7:0],[15:8],[23:16],[31:24] to input byte addresses inp0..inp0+3, where address = row*MAX_CHANNELS+ch and inp0[1:0] is ignored.
REQ-016 SHALL decode cmd 2 as: write kernel, with the same packing and address = tap*MAX_CHANNELS+ch.
REQ-017 SHALL decode cmd 3 as: ret <= output[inp0] on the next edge.
REQ-018 SHALL decode cmd 4 as: start.
REQ-019 SHALL decode cmd 5 and cmd 6 as: ret <= the packed input word and kernel word at inp0, respectively.
REQ-020 SHALL decode cmd 7 as: bias <= inp0.
REQ-021 SHALL decode cmd 8 as: input_offset <= inp0[8:0] (signed).
REQ-022 SHALL decode cmd 9 as: input_len <= inp0, channels <= inp1[15:0], stride <= inp1[17:16] (0 treated as 1).
REQ-023 SHALL decode cmd 10 as: ret <= {busy, output_buffer_valid, num_out}.
REQ-024 SHALL treat all other cmd codes as NOP.
REQ-025 SHALL compute num_out = (input_len - KERNEL_LEN)/stride + 1; padding is the software's responsibility.
REQ-026 SHALL compute output[o] = bias + sum over taps k and channels c of (in[o*stride+k][c] + input_offset) * w[k][c]; 8-bit operands are signed, each product is 17-bit signed, the sum is ACC_W-bit two's-complement with wrap.
REQ-027 SHALL use FSM states IDLE, RUN, DONE; start moves IDLE or DONE to RUN, clears output_buffer_valid, sets busy, and loads acc with bias.
REQ-028 SHALL perform, in RUN, one step per cycle: 4 channel MACs at (o, k, group g); g iterates innermost, then k, then o.
REQ-029 SHALL, on the final step for each o, write acc+products to output[o] and reload acc with bias.
REQ-030 SHALL, after the last step of the last o, enter DONE on that edge with busy=0 and output_buffer_valid=1; latency from the start edge is num_out*KERNEL_LEN*(channels/4) cycles.
REQ-031 SHALL, while busy, ignore cmd 1, 2, 4, 7, 8 and 9; reads remain serviced, and output reads return stale data.
REQ-032 SHALL, on start with num_out<1 or channels=0, go directly to DONE in 1 cycle with the output buffer unchanged.
REQ-033 SHALL ignore out-of-range addresses for writes and return 0 for out-of-range reads.

Reset
REQ-034 SHALL, while rst_n=0, place the FSM in IDLE with busy=0, output_buffer_valid=0, ret=0, bias=0, input_offset=0, input_len=0, channels=0, stride=1; buffer contents are unaffected.
REQ-035 SHALL, on reset during RUN, abort the computation; outputs become invalid until the next completed start.

Structure
REQ-036 SHALL place cmd codes, FSM state enum, and operand/product widths in package conv1d_v4_pkg.
REQ-037 SHALL instantiate one sub-module conv1d_v4_mac4: a combinational 4-lane signed (in+offset)*w adder tree.

Verification
REQ-038 SHALL test: 16 rows, 2 channels (ch0 0,0,0,0,7,6,5,4,3,2,1,0,0,0,0,0; ch1 0,0,0,0,0,1,2,3,4,5,6,7,0,0,0,0), all taps {2,1}, bias 1, channels=4, stride 1 -> output[0]=51, output[4]=85, 9 outputs.
REQ-039 SHALL test: the same data with stride 2 -> num_out=5, output[1]=70.
REQ-040 SHALL test: the same data with input_offset -1 -> output[0]=27.
REQ-041 SHALL test latency: start -> busy=1 for exactly 72 cycles (stride 1 case), then output_buffer_valid=1.
REQ-042 SHALL test: cmd 7 and cmd 1 issued while busy -> no effect on result; rst_n pulse mid-RUN -> busy=0, valid=0, ret=0.
REQ-043 SHALL test: read-back via cmd 5/6 of the written words -> exact match, e.g. 0x00000106 at row 5.

Source files
------------

// File: rtl/conv1d_v4_pkg.sv
// Shared command codes, FSM states and datapath widths for the conv1d_v4 engine.
package conv1d_v4_pkg;

    localparam int CMD_W = 7;

    localparam logic [CMD_W-1:0] CMD_NOP    = 7'd0;
    localparam logic [CMD_W-1:0] CMD_WR_IN  = 7'd1;
    localparam logic [CMD_W-1:0] CMD_WR_KER = 7'd2;
    localparam logic [CMD_W-1:0] CMD_RD_OUT = 7'd3;
    localparam logic [CMD_W-1:0] CMD_START  = 7'd4;
    localparam logic [CMD_W-1:0] CMD_RD_IN  = 7'd5;
    localparam logic [CMD_W-1:0] CMD_RD_KER = 7'd6;
    localparam logic [CMD_W-1:0] CMD_BIAS   = 7'd7;
    localparam logic [CMD_W-1:0] CMD_OFFSET = 7'd8;
    localparam logic [CMD_W-1:0] CMD_CFG    = 7'd9;
    localparam logic [CMD_W-1:0] CMD_STATUS = 7'd10;

    // Operand byte, offset, offset-corrected operand, lane product, 4-lane sum
    localparam int OPND_W = 8;
    localparam int OFS_W  = 9;
    localparam int SUM_W  = 10;
    localparam int PROD_W = 17;
    localparam int TREE_W = 19;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/conv1d_v4_mac4.sv
// Combinational 4-lane signed (in + offset) * w multiply with adder tree.
module conv1d_v4_mac4
    import conv1d_v4_pkg::*;
(
    input  logic [31:0]              data,
    input  logic [31:0]              weight,
    input  logic signed [OFS_W-1:0]  offset,
    output logic signed [TREE_W-1:0] sum
);

    logic signed [SUM_W-1:0]  lane_in   [4];
    logic signed [PROD_W-1:0] lane_prod [4];

    // Offset-correct each input byte, multiply by its weight byte, accumulate the lanes
    always_comb begin
        sum = '0;
        for (int i = 0; i < 4; i++) begin
            lane_in[i]   = SUM_W'($signed(data[OPND_W*i +: OPND_W])) + SUM_W'(offset);
            lane_prod[i] = PROD_W'(lane_in[i]) * PROD_W'($signed(weight[OPND_W*i +: OPND_W]));
            sum          = sum + TREE_W'(lane_prod[i]);
        end
    end

endmodule

// File: rtl/conv1d_v4.sv
// 1-D convolution engine: byte-packed input/kernel buffers, command decode,
// and an IDLE/RUN/DONE sequencer stepping 4 channels per cycle.
module conv1d_v4
    import conv1d_v4_pkg::*;
#(
    parameter int KERNEL_LEN    = 8,
    parameter int MAX_INPUT_LEN = 1024,
    parameter int MAX_CHANNELS  = 128,
    parameter int ACC_W         = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [CMD_W-1:0]        cmd,
    input  logic signed [31:0]      inp0,
    input  logic signed [31:0]      inp1,
    output logic                    output_buffer_valid,
    output logic                    busy,
    output logic signed [ACC_W-1:0] ret
);

    localparam int GRP       = MAX_CHANNELS / 4;
    localparam int IN_WORDS  = MAX_INPUT_LEN * GRP;
    localparam int KER_WORDS = KERNEL_LEN * GRP;
    localparam int IN_AW     = $clog2(IN_WORDS);
    localparam int KER_AW    = $clog2(KER_WORDS);
    localparam int OUT_AW    = $clog2(MAX_INPUT_LEN);

    logic [31:0]             in_mem  [IN_WORDS];
    logic [31:0]             ker_mem [KER_WORDS];
    logic signed [ACC_W-1:0] out_mem [MAX_INPUT_LEN];

    state_t                  state;
    logic signed [ACC_W-1:0] bias, acc, acc_next;
    logic signed [OFS_W-1:0] input_offset;
    logic [31:0]             input_len, num_out, num_out_q, len_diff, len_quot;
    logic [31:0]             o_cnt, k_cnt, row_base, run_row;
    logic [15:0]             channels, groups, groups_q, g_cnt;
    logic [1:0]              stride;

    logic [31:0]             host_word, host_addr;
    logic                    host_in_ok, host_ker_ok, host_out_ok;
    logic [47:0]             run_in_word;
    logic [31:0]             run_ker_word;
    logic                    run_in_ok, run_ker_ok;
    logic [31:0]             mac_data, mac_weight;
    logic signed [TREE_W-1:0] mac_sum;
    logic                    last_g, last_k, last_o, step_end, in_we, ker_we, out_we;
    logic                    unused_bits;

    // Host-side address decode; byte addresses collapse to word addresses
    always_comb begin
        host_word   = {2'b00, inp0[31:2]};
        host_addr   = inp0;
        host_in_ok  = host_word < 32'(IN_WORDS);
        host_ker_ok = host_word < 32'(KER_WORDS);
        host_out_ok = host_addr < 32'(MAX_INPUT_LEN);
        in_we       = !busy && (cmd == CMD_WR_IN) && host_in_ok;
        ker_we      = !busy && (cmd == CMD_WR_KER) && host_ker_ok;
    end

    // Output count from the live configuration; short inputs yield zero outputs
    always_comb begin
        len_diff = input_len - 32'(KERNEL_LEN);
        case (stride)
            2'd2:    len_quot = len_diff >> 1;
            2'd3:    len_quot = len_diff / 32'd3;
            default: len_quot = len_diff;
        endcase
        num_out = ($signed(input_len) < KERNEL_LEN) ? 32'd0 : len_quot + 32'd1;
        groups  = {2'b00, channels[15:2]};
    end

    // Operand fetch for the current (o, k, g) step; rows past the buffer read as zero
    always_comb begin
        run_row      = row_base + k_cnt;
        run_in_word  = 48'(run_row) * 48'(GRP) + 48'(g_cnt);
        run_ker_word = k_cnt * 32'(GRP) + 32'(g_cnt);
        run_in_ok    = (run_row < 32'(MAX_INPUT_LEN)) && (g_cnt < 16'(GRP));
        run_ker_ok   = g_cnt < 16'(GRP);
        mac_data     = run_in_ok  ? in_mem[run_in_word[IN_AW-1:0]]    : 32'd0;
        mac_weight   = run_ker_ok ? ker_mem[run_ker_word[KER_AW-1:0]] : 32'd0;
    end

    conv1d_v4_mac4 u_mac4 (
        .data   (mac_data),
        .weight (mac_weight),
        .offset (input_offset),
        .sum    (mac_sum)
    );

    // Step bookkeeping; an output is complete when both group and tap wrap
    always_comb begin
        acc_next = acc + ACC_W'(mac_sum);
        last_g   = g_cnt == groups_q - 16'd1;
        last_k   = k_cnt == 32'(KERNEL_LEN - 1);
        last_o   = o_cnt == num_out_q - 32'd1;
        step_end = (state == RUN) && last_g && last_k;
        out_we   = step_end && (o_cnt < 32'(MAX_INPUT_LEN));
    end

    // Buffer writes: host loads input/kernel words, the sequencer stores results
    always_ff @(posedge clk) begin
        if (in_we)  in_mem[host_word[IN_AW-1:0]]   <= inp1;
        if (ker_we) ker_mem[host_word[KER_AW-1:0]] <= inp1;
        if (out_we) out_mem[o_cnt[OUT_AW-1:0]]     <= acc_next;
    end

    // Command execution, configuration registers and the IDLE/RUN/DONE sequencer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= IDLE;
            busy                <= 1'b0;
            output_buffer_valid <= 1'b0;
            ret                 <= '0;
            bias                <= '0;
            input_offset        <= '0;
            input_len           <= '0;
            channels            <= '0;
            stride              <= 2'd1;
            acc                 <= '0;
            o_cnt               <= '0;
            k_cnt               <= '0;
            g_cnt               <= '0;
            row_base            <= '0;
            num_out_q           <= '0;
            groups_q            <= '0;
        end else begin
            case (cmd)
                CMD_RD_OUT: ret <= host_out_ok ? out_mem[host_addr[OUT_AW-1:0]] : '0;
                CMD_RD_IN:  ret <= host_in_ok  ? ACC_W'(in_mem[host_word[IN_AW-1:0]])   : '0;
                CMD_RD_KER: ret <= host_ker_ok ? ACC_W'(ker_mem[host_word[KER_AW-1:0]]) : '0;
                CMD_STATUS: ret <= {busy, output_buffer_valid, (ACC_W-2)'(num_out)};
                default: ;
            endcase
            if (!busy) begin
                case (cmd)
                    CMD_BIAS:   bias         <= ACC_W'(inp0);
                    CMD_OFFSET: input_offset <= inp0[OFS_W-1:0];
                    CMD_CFG: begin
                        input_len <= inp0;
                        channels  <= inp1[15:0];
                        stride    <= (inp1[17:16] == 2'd0) ? 2'd1 : inp1[17:16];
                    end
                    default: ;
                endcase
            end
            case (state)
                IDLE, DONE: begin
                    if (cmd == CMD_START) begin
                        acc       <= bias;
                        o_cnt     <= '0;
                        k_cnt     <= '0;
                        g_cnt     <= '0;
                        row_base  <= '0;
                        num_out_q <= num_out;
                        groups_q  <= groups;
                        if ((num_out == 32'd0) || (groups == 16'd0)) begin
                            state               <= DONE;
                            busy                <= 1'b0;
                            output_buffer_valid <= 1'b1;
                        end else begin
                            state               <= RUN;
                            busy                <= 1'b1;
                            output_buffer_valid <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (last_g && last_k) begin
                        acc      <= bias;
                        g_cnt    <= '0;
                        k_cnt    <= '0;
                        o_cnt    <= o_cnt + 32'd1;
                        row_base <= row_base + 32'(stride);
                        if (last_o) begin
                            state               <= DONE;
                            busy                <= 1'b0;
                            output_buffer_valid <= 1'b1;
                        end
                    end else begin
                        acc <= acc_next;
                        if (last_g) begin
                            g_cnt <= '0;
                            k_cnt <= k_cnt + 32'd1;
                        end else begin
                            g_cnt <= g_cnt + 16'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign unused_bits = ^{inp1, host_word, host_addr, run_in_word, run_ker_word, num_out};

endmodule
